// File: rtl/eq_band_sequencer_pkg.sv
// Shared types and constants for the ten-band equalizer sequencer.
// Holds the band count, timing constants, state encoding and band command codes.
package eq_band_sequencer_pkg;

    localparam int NBANDS = 10;
    localparam int GUARD  = 2;
    localparam int TOW    = 12;
    localparam int ACCW   = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_GUARD,
        ST_POLL,
        ST_SUM,
        ST_OUT
    } state_t;

    localparam logic [2:0] CMD_TAPS   = 3'd0;
    localparam logic [2:0] CMD_COEFF  = 3'd1;
    localparam logic [2:0] CMD_ATTEN  = 3'd2;
    localparam logic [2:0] CMD_CONV   = 3'd3;
    localparam logic [3:0] BAND_BCAST = 4'hF;

    // Band select mask for a config target; out-of-range targets give an empty mask.
    function automatic logic [NBANDS-1:0] band_mask(input logic [3:0] band);
        logic [NBANDS-1:0] m;
        m = '0;
        if (band == BAND_BCAST) begin
            m = '1;
        end else begin
            for (int b = 0; b < NBANDS; b++) begin
                if (band == 4'(b)) m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/eq_band_sequencer_if.sv
// Host, band-bus and output signals of the equalizer sequencer.
// Cfg handshake: a request transfers on a cycle with CfgValid && CfgReady; the host holds CfgValid/CfgBand/CfgWord stable until then.
interface eq_band_sequencer_if;
    import eq_band_sequencer_pkg::*;

    logic                   SampleStrobe;
    logic                   CfgValid;
    logic [3:0]             CfgBand;
    logic [31:0]            CfgWord;
    logic                   CfgReady;
    logic [NBANDS-1:0]      PSel;
    logic                   PEnable;
    logic                   PWrite;
    logic [31:0]            PWData;
    logic [NBANDS*32-1:0]   PRDataAll;
    logic                   OutValid;
    logic [15:0]            OutSample;
    logic                   Busy;
    logic                   Overrun;
    logic                   Timeout;
    logic                   ErrClr;

    modport master (
        input  SampleStrobe, CfgValid, CfgBand, CfgWord, PRDataAll, ErrClr,
        output CfgReady, PSel, PEnable, PWrite, PWData, OutValid, OutSample,
               Busy, Overrun, Timeout
    );

    modport slave (
        output SampleStrobe, CfgValid, CfgBand, CfgWord, PRDataAll, ErrClr,
        input  CfgReady, PSel, PEnable, PWrite, PWData, OutValid, OutSample,
               Busy, Overrun, Timeout
    );

endinterface

// File: rtl/eq_band_sequencer_sat_accum.sv
// Signed accumulator for band outputs with a saturated 16-bit (1.15) view of the running sum.
module eq_band_sequencer_sat_accum
    import eq_band_sequencer_pkg::*;
#(
    parameter int W = ACCW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               add_en,
    input  logic signed [15:0] add_val,
    output logic [15:0]        sat_out
);

    localparam logic signed [W-1:0] SAT_HI = W'(32'sd32767);
    localparam logic signed [W-1:0] SAT_LO = ~SAT_HI;

    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = acc_q + $signed({{(W-16){add_val[15]}}, add_val});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    always_comb begin
        if (acc_q > SAT_HI)      sat_out = 16'h7FFF;
        else if (acc_q < SAT_LO) sat_out = 16'h8000;
        else                     sat_out = acc_q[15:0];
    end

endmodule

// File: rtl/eq_band_sequencer.sv
// Drives the band filters over their shared write bus: convolve broadcast per sample, wait for Ready,
// saturating sum of band outputs; host config words are forwarded to one band or all bands between samples.
module eq_band_sequencer
    import eq_band_sequencer_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    eq_band_sequencer_if.master bus,
    output state_t              dbg_state
);

    localparam int GW   = $clog2(GUARD + 1);
    localparam int SUMW = $clog2(NBANDS);
    localparam logic [TOW-1:0] TO_LAST = {{(TOW-1){1'b1}}, 1'b0};

    state_t            state_q, state_d;
    logic [NBANDS-1:0] mask_q, mask_d;
    logic              conv_q, conv_d;
    logic [NBANDS-1:0] psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [GW-1:0]     guard_cnt_q, guard_cnt_d;
    logic [TOW-1:0]    to_cnt_q, to_cnt_d;
    logic [SUMW-1:0]   sum_idx_q, sum_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_sample_q, out_sample_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic              cfg_ready;
    logic [NBANDS-1:0] ready_vec;
    logic              all_ready;
    logic [NBANDS-1:0] cfg_mask;
    logic              acc_clear;
    logic              acc_add;
    logic signed [15:0] add_val;
    logic [15:0]       sat_sum;
    logic              timeout_set;
    logic              prdata_unused;

    assign cfg_ready = (state_q == ST_IDLE) & ~bus.SampleStrobe & ~Reset;
    assign cfg_mask  = band_mask(bus.CfgBand);
    assign all_ready = &(ready_vec | ~mask_q);

    always_comb begin
        ready_vec     = '0;
        add_val       = '0;
        prdata_unused = 1'b0;
        for (int b = 0; b < NBANDS; b++) begin
            ready_vec[b]  = bus.PRDataAll[32*b+31];
            prdata_unused = prdata_unused ^ (^bus.PRDataAll[32*b+16 +: 15]);
            if (sum_idx_q == SUMW'(b)) add_val = $signed(bus.PRDataAll[32*b +: 16]);
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        conv_d       = conv_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        guard_cnt_d  = guard_cnt_q;
        to_cnt_d     = to_cnt_q;
        sum_idx_d    = sum_idx_q;
        out_valid_d  = 1'b0;
        out_sample_d = out_sample_q;
        acc_clear    = 1'b0;
        acc_add      = 1'b0;
        timeout_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.SampleStrobe) begin
                    state_d   = ST_SETUP;
                    mask_d    = '1;
                    conv_d    = 1'b1;
                    pwdata_d  = {29'b0, CMD_CONV};
                    psel_d    = '1;
                    pwrite_d  = 1'b1;
                    penable_d = 1'b0;
                end else if (bus.CfgValid && (cfg_mask != '0)) begin
                    state_d   = ST_SETUP;
                    mask_d    = cfg_mask;
                    conv_d    = 1'b0;
                    pwdata_d  = bus.CfgWord;
                    psel_d    = cfg_mask;
                    pwrite_d  = 1'b1;
                    penable_d = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                state_d     = ST_GUARD;
                psel_d      = '0;
                penable_d   = 1'b0;
                pwrite_d    = 1'b0;
                guard_cnt_d = '0;
            end
            ST_GUARD: begin
                // Ready is stale until the bands have seen the write and dropped it.
                if (guard_cnt_q == GW'(GUARD - 1)) begin
                    state_d  = ST_POLL;
                    to_cnt_d = '0;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            ST_POLL: begin
                if (all_ready) begin
                    if (conv_q) begin
                        state_d   = ST_SUM;
                        sum_idx_d = '0;
                        acc_clear = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_SUM: begin
                acc_add = 1'b1;
                if (sum_idx_q == SUMW'(NBANDS - 1)) state_d = ST_OUT;
                else                                sum_idx_d = sum_idx_q + 1'b1;
            end
            ST_OUT: begin
                out_sample_d = sat_sum;
                out_valid_d  = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Error flags are sticky; a new error in the clearing cycle still sticks.
        overrun_d = overrun_q & ~bus.ErrClr;
        if (bus.SampleStrobe && (state_q != ST_IDLE)) overrun_d = 1'b1;
        timeout_d = timeout_q & ~bus.ErrClr;
        if (timeout_set) timeout_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            conv_q       <= 1'b0;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            guard_cnt_q  <= '0;
            to_cnt_q     <= '0;
            sum_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            conv_q       <= conv_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            guard_cnt_q  <= guard_cnt_d;
            to_cnt_q     <= to_cnt_d;
            sum_idx_q    <= sum_idx_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    eq_band_sequencer_sat_accum #(.W(ACCW)) u_accum (
        .clk     (Clk),
        .rst     (Reset),
        .clear   (acc_clear),
        .add_en  (acc_add),
        .add_val (add_val),
        .sat_out (sat_sum)
    );

    assign bus.CfgReady  = cfg_ready;
    assign bus.PSel      = psel_q;
    assign bus.PEnable   = penable_q;
    assign bus.PWrite    = pwrite_q;
    assign bus.PWData    = pwdata_q;
    assign bus.OutValid  = out_valid_q;
    assign bus.OutSample = out_sample_q;
    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.Overrun   = overrun_q;
    assign bus.Timeout   = timeout_q;
    assign dbg_state     = state_q;

endmodule
